// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter/sequencer.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int   ID_W           = 1;
    localparam logic ALU_DRV_RST    = 1'b0;
    localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way round-robin: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // Grant selection from current valids and last-grant history
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared ALU: grant, hold operands for ALU_LATENCY cycles,
// then present the tagged result until the consumer accepts it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int OP_W        = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_rs0,
    input  logic [WIDTH-1:0] req_rt0,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [WIDTH-1:0] req_rs1,
    input  logic [WIDTH-1:0] req_rt1,
    input  logic [OP_W-1:0]  req_op1,
    output logic [WIDTH-1:0] alu_rs,
    output logic [WIDTH-1:0] alu_rt,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] w_grant;
    logic       r_last;
    logic [2:0] r_cnt;
    logic       w_take;
    logic       w_done;

    rr_arb2 u_arb (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_take = (r_state == ST_IDLE) && (req_valid != 2'b00);
    assign w_done = (r_state == ST_EXEC) && (r_cnt == 3'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; leaving RESP never overlaps a new grant
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_take ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_state_nxt = w_done ? ST_RESP : ST_EXEC;
            ST_RESP: w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; req_ready is the only combinational path from req_valid
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                busy      = 1'b0;
            end
            ST_EXEC: busy = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: begin
                req_ready = 2'b00;
                busy      = 1'b0;
            end
        endcase
    end

    // Operand capture at grant, latency countdown, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rs   <= {WIDTH{ALU_DRV_RST}};
            alu_rt   <= {WIDTH{ALU_DRV_RST}};
            alu_op   <= {OP_W{ALU_DRV_RST}};
            rsp_id   <= {ID_W{1'b0}};
            rsp_data <= {WIDTH{1'b0}};
            r_last   <= LAST_GRANT_RST;
            r_cnt    <= 3'd0;
        end else if (w_take) begin
            alu_rs <= w_grant[1] ? req_rs1 : req_rs0;
            alu_rt <= w_grant[1] ? req_rt1 : req_rt0;
            alu_op <= w_grant[1] ? req_op1 : req_op0;
            rsp_id <= w_grant[1];
            r_last <= w_grant[1];
            r_cnt  <= LAT_LOAD;
        end else if (r_state == ST_EXEC) begin
            r_cnt <= r_cnt - 3'd1;
            if (w_done) begin
                rsp_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LATENCY=1, one at ALU_LATENCY=3.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_valid3 = 2'b00;
    logic       rsp_ready = 1'b1;
    logic       rsp_ready3 = 1'b1;
    logic [3:0] rs0 = 4'd0, rt0 = 4'd0, rs1 = 4'd0, rt1 = 4'd0;
    logic [1:0] op0 = 2'd0, op1 = 2'd0;

    logic [1:0] req_ready, req_ready3;
    logic [3:0] alu_rs, alu_rt, alu_result, rsp_data;
    logic [3:0] alu_rs3, alu_rt3, alu_result3, rsp_data3;
    logic [1:0] alu_op, alu_op3;
    logic       rsp_valid, rsp_id, busy;
    logic       rsp_valid3, rsp_id3, busy3;
    logic [3:0] s1 = 4'd0, s2 = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU models: combinational for latency 1, two register stages for latency 3
    assign alu_result  = alu_f(alu_rs, alu_rt, alu_op);
    always @(posedge clk) begin
        s1 <= alu_f(alu_rs3, alu_rt3, alu_op3);
        s2 <= s1;
    end
    assign alu_result3 = s2;

    alu_arbiter #(.WIDTH(4), .OP_W(2), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs0(rs0), .req_rt0(rt0), .req_op0(op0),
        .req_rs1(rs1), .req_rt1(rt1), .req_op1(op1),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    alu_arbiter #(.WIDTH(4), .OP_W(2), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_rs0(rs0), .req_rt0(rt0), .req_op0(op0),
        .req_rs1(rs1), .req_rt1(rt1), .req_op1(op1),
        .alu_rs(alu_rs3), .alu_rt(alu_rt3), .alu_op(alu_op3), .alu_result(alu_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_data(rsp_data3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".alu"}, 32'({alu_rs, alu_rt, alu_op}), 32'd0);
        chk({tag, ".rsp"}, 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        chk("reset.dut3", 32'({req_ready3, alu_rs3, rsp_valid3, busy3}), 32'd0);
        #9 rst_n = 1'b1;
        tick;

        // Single request: 3 + 5 from requester 0
        req_valid = 2'b01; rs0 = 4'd3; rt0 = 4'd5; op0 = 2'd0;
        #1 chk("single.ready", 32'(req_ready), 32'h1);
        tick;
        chk("single.ready_exec", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        chk("single.alu", 32'({alu_rs, alu_rt, alu_op}), 32'({4'd3, 4'd5, 2'd0}));
        chk("single.busy", 32'(busy), 32'h1);
        chk("single.rsp_early", 32'(rsp_valid), 32'h0);
        tick;
        chk("single.rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 4'd8}));
        tick;
        chk("single.idle", 32'({rsp_valid, busy}), 32'h0);

        // Tie from reset: grants 0,1,0,1 every third cycle
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        rs0 = 4'd1; rt0 = 4'd2; op0 = 2'd0;
        rs1 = 4'd7; rt1 = 4'd2; op1 = 2'd1;
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 0) begin
                chk("tie.grant", 32'(req_ready), ((c / 3) % 2 == 0) ? 32'h1 : 32'h2);
            end else begin
                chk("tie.nogrant", 32'(req_ready), 32'h0);
            end
            if (c % 3 == 2) begin
                chk("tie.rsp", 32'({rsp_valid, rsp_id, rsp_data}),
                    ((c / 3) % 2 == 0) ? 32'({1'b1, 1'b0, 4'd3}) : 32'({1'b1, 1'b1, 4'd5}));
            end
            tick;
        end
        req_valid = 2'b00;
        tick;

        // Backpressure: 9 ^ 4 held for 10 cycles
        req_valid = 2'b01; rs0 = 4'd9; rt0 = 4'd4; op0 = 2'd3; rsp_ready = 1'b0;
        tick;
        req_valid = 2'b11;
        tick;
        for (int i = 0; i < 10; i++) begin
            chk("bp.rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 4'd13}));
            chk("bp.ready", 32'(req_ready), 32'h0);
            chk("bp.busy", 32'(busy), 32'h1);
            tick;
        end
        rsp_ready = 1'b1; req_valid = 2'b00;
        tick;
        chk("bp.release", 32'({rsp_valid, busy}), 32'h0);

        // Withdrawn request from requester 1 during RESP
        req_valid = 2'b01; rs0 = 4'd2; rt0 = 4'd2; op0 = 2'd0; rsp_ready = 1'b0;
        #1 chk("wd.grant", 32'(req_ready), 32'h1);
        tick;
        req_valid = 2'b00;
        tick;
        req_valid = 2'b10;
        #1 chk("wd.ready_resp", 32'(req_ready), 32'h0);
        tick;
        chk("wd.ready_resp2", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        chk("wd.rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 4'd4}));
        rsp_ready = 1'b1;
        tick;
        chk("wd.idle", 32'({req_ready, rsp_valid, busy}), 32'h0);
        tick;
        chk("wd.no_spurious", 32'({req_ready, rsp_valid, busy}), 32'h0);

        // Reset during EXEC after a requester-0 grant
        req_valid = 2'b01; rs0 = 4'd1; rt0 = 4'd1; op0 = 2'd0;
        tick;
        req_valid = 2'b00;
        chk("rst.exec_busy", 32'(busy), 32'h1);
        chk("rst.exec_alu", 32'(alu_rs), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst.async");
        tick;
        chk("rst.no_rsp", 32'({rsp_valid, busy}), 32'h0);
        #2 rst_n = 1'b1;
        req_valid = 2'b11;
        #1 chk("rst.tie_grant", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        tick;
        chk("rst.still_no_rsp", 32'({rsp_valid, busy}), 32'h0);

        // Latency 3 instance: requester 1, 6 & 3
        req_valid3 = 2'b10; rs1 = 4'd6; rt1 = 4'd3; op1 = 2'd2;
        #1 chk("lat3.grant", 32'(req_ready3), 32'h2);
        tick;
        req_valid3 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            chk("lat3.alu", 32'({alu_rs3, alu_rt3, alu_op3}), 32'({4'd6, 4'd3, 2'd2}));
            chk("lat3.rsp_early", 32'(rsp_valid3), 32'h0);
            tick;
        end
        chk("lat3.rsp", 32'({rsp_valid3, rsp_id3, rsp_data3}), 32'({1'b1, 1'b1, 4'd2}));
        tick;
        chk("lat3.idle", 32'({rsp_valid3, busy3}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU. It accepts operation requests (operands plus 2-bit arithmetic select) from two independent masters over valid/ready handshakes and grants the ALU round-robin. It holds the ALU inputs stable for the ALU's registered latency, then returns the tagged result over a valid/ready response channel. It sits between the top-level pin decode and the ALU instance.

## Interface
Parameters:
- WIDTH, 4: operand and result width
- OP_W, 2: arithmetic-select width (ALU mux code, passed through unmodified)
- ALU_LATENCY, 1: cycles from ALU inputs stable to alu_result valid; legal range 1..7

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept; one-hot or zero
- req_rs0, req_rt0  in  WIDTH each  requester 0 operands
- req_op0  in  OP_W  requester 0 arithmetic select
- req_rs1, req_rt1  in  WIDTH each  requester 1 operands
- req_op1  in  OP_W  requester 1 arithmetic select
- alu_rs, alu_rt  out  WIDTH each  to ALU operand inputs
- alu_op  out  OP_W  to ALU arithmetic mux select
- alu_result  in  WIDTH  from ALU output
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester that issued the response
- rsp_data  out  WIDTH  captured ALU result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is set, assert req_ready for the winner combinationally in the same cycle. Capture the winner's rs/rt/op and id into registers, load the latency counter with ALU_LATENCY, and go to EXEC. If no request is valid, stay in IDLE.
- Arbitration: one valid requester wins outright. If both are valid, the requester not granted last wins. The last-grant register resets to 1, so requester 0 wins the first tie. The last-grant register updates at grant.
- EXEC: alu_rs/alu_rt/alu_op drive the captured registers. The counter decrements each cycle. When the counter is 1, capture alu_result into rsp_data and go to RESP.
- RESP: rsp_valid=1; rsp_id and rsp_data stay stable. When rsp_ready=1, go to IDLE. No new grant is made in the RESP→IDLE transition cycle.
- req_ready is 0 in EXEC and RESP. Requests are not queued; requesters hold valid until ready.
- Arithmetic: the arbiter does not interpret op or data. rsp_data equals alu_result bit-for-bit.

## Timing
- Reset values: req_ready=0, alu_rs=alu_rt=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, state=IDLE, last-grant=1.
- Grant at cycle T (IDLE, req_valid&req_ready). ALU inputs stable from T+1. Result captured at the end of cycle T+ALU_LATENCY. rsp_valid rises at T+ALU_LATENCY+1.
- Minimum issue interval with rsp_ready tied high: ALU_LATENCY+2 cycles.
- rsp_ready held low: the response holds indefinitely and both req_ready bits stay 0.
- req_valid dropping while not granted: this is legal and nothing is captured. A requester may change operands while not granted.
- rst_n asserted mid-EXEC or mid-RESP: the in-flight operation is discarded with no response. All outputs go to reset values immediately (asynchronous). Operation resumes in IDLE on the first clock edge after deassertion.
- alu_* outputs are registered; there is no combinational path from req_* to alu_*. req_ready depends combinationally on req_valid and state only.

## Structure
- Package alu_arbiter_pkg holds: the state enum (IDLE, EXEC, RESP), the requester-id width constant (1), and the reset-value constants for the ALU drive registers.
- One sub-module: rr_arb2 (2-way round-robin, inputs valid[1:0] and last, output grant one-hot). It is purely combinational; the last-grant register lives in alu_arbiter.
- The ALU itself is not instantiated here. The top level connects alu_* to the ALU instance and ties the ALU reset from rst_n.

## Test plan
- Single request: requester 0 sends rs=3, rt=5, op=0; the ALU model returns 8 after 1 cycle. Required: req_ready[0] pulses for 1 cycle, then rsp_valid at grant+2 with rsp_id=0 and rsp_data=8.
- Tie: both valid from reset. Required: grant order 0,1,0,1 over four back-to-back ops with rsp_ready=1; grants are spaced 3 cycles apart (ALU_LATENCY=1).
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP. Required: rsp_data and rsp_id are stable, req_ready=00 and busy=1 throughout, then return to IDLE one cycle after rsp_ready=1.
- Latency parameter: ALU_LATENCY=3 with requester 1 sending op=2. Required: alu_* held for 3 cycles, rsp_valid at grant+4, and data equals the model output at that point.
- Reset mid-op: assert rst_n=0 during EXEC. Required: rsp_valid never asserts for that op, all outputs are 0 asynchronously, and the next tie grants requester 0.
- Withdrawn request: requester 1 pulses valid during RESP of requester 0's op, then drops it. Required: no grant to 1 and no spurious response.
